// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer slice.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        HOLD_LAST
    } anim_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: steps through sprite frames once per video frame,
// holding each frame for FRAME_HOLD video frames.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               frame_start_i,
    input  logic               anim_play_i,
    input  logic               anim_loop_i,
    input  logic               anim_restart_i,
    output logic [FRAME_W-1:0] anim_frame_o,
    output logic               anim_done_o
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

    anim_state_t        state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               done_q, done_d;
    logic               step;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    // Leaving IDLE counts as a played video frame, so playback starts on
    // the same frame_start that sees anim_play.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        step    = 1'b0;
        if (anim_restart_i) begin
            frame_d = '0;
            hold_d  = '0;
            state_d = anim_play_i ? PLAY : IDLE;
        end else if (frame_start_i) begin
            case (state_q)
                IDLE: begin
                    if (anim_play_i) begin
                        state_d = PLAY;
                        step    = 1'b1;
                    end
                end
                PLAY: begin
                    if (anim_play_i) step = 1'b1;
                    else             state_d = IDLE;
                end
                HOLD_LAST: state_d = HOLD_LAST;
                default:   state_d = IDLE;
            endcase
            if (step) begin
                if (hold_q == HOLD_MAX) begin
                    hold_d = '0;
                    if (frame_q == LAST_FRAME) begin
                        done_d = 1'b1;
                        if (anim_loop_i) frame_d = '0;
                        else             state_d = HOLD_LAST;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end
    end

    assign anim_frame_o = frame_q;
    assign anim_done_o  = done_q;

endmodule

// File: rtl/sprite_anim_renderer.sv
// Single-sprite renderer: hit test, texel addressing into a synchronous ROM,
// and a two-stage pipeline producing a palette index plus opaque-hit flag.
module sprite_anim_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_HOLD  = 8,
    parameter int SCALE_SHIFT = 0,
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(NUM_FRAMES * SPR_W * SPR_H),
    parameter int FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  coord_t             DrawX,
    input  coord_t             DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  coord_t             pos_x,
    input  coord_t             pos_y,
    input  logic               flip_h,
    input  logic               anim_play,
    input  logic               anim_loop,
    input  logic               anim_restart,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pix_index,
    output logic               pix_hit,
    output logic [FRAME_W-1:0] anim_frame,
    output logic               anim_done
);

    localparam int LX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int LY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [10:0] EXT_W = 11'(SPR_W << SCALE_SHIFT);
    localparam logic [10:0] EXT_H = 11'(SPR_H << SCALE_SHIFT);

    coord_t            sx_q, sy_q;
    logic              flip_q;
    logic              hit_d1_q;
    logic [IDX_W-1:0]  pix_index_q;
    logic              pix_hit_q;

    logic [10:0]       dx, dy;
    logic              hit;
    logic [LX_W-1:0]   lx_raw, lx;
    logic [LY_W-1:0]   ly;
    logic [ADDR_W-1:0] texel_addr;

    sprite_anim_ctrl #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FRAME_W    (FRAME_W)
    ) u_ctrl (
        .clk            (vga_clk),
        .srst           (reset),
        .frame_start_i  (frame_start),
        .anim_play_i    (anim_play),
        .anim_loop_i    (anim_loop),
        .anim_restart_i (anim_restart),
        .anim_frame_o   (anim_frame),
        .anim_done_o    (anim_done)
    );

    // Bit 10 of the zero-extended difference is the borrow, i.e. DrawX < sx.
    assign dx  = {1'b0, DrawX} - {1'b0, sx_q};
    assign dy  = {1'b0, DrawY} - {1'b0, sy_q};
    assign hit = !dx[10] && !dy[10] && (dx < EXT_W) && (dy < EXT_H);

    assign lx_raw = LX_W'(dx >> SCALE_SHIFT);
    assign ly     = LY_W'(dy >> SCALE_SHIFT);
    assign lx     = flip_q ? (LX_W'(SPR_W - 1) - lx_raw) : lx_raw;

    assign texel_addr = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H)
                      + ADDR_W'(ly) * ADDR_W'(SPR_W)
                      + ADDR_W'(lx);
    assign rom_address = hit ? texel_addr : '0;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sx_q        <= '0;
            sy_q        <= '0;
            flip_q      <= 1'b0;
            hit_d1_q    <= 1'b0;
            pix_index_q <= '0;
            pix_hit_q   <= 1'b0;
        end else begin
            if (frame_start) begin
                sx_q   <= pos_x;
                sy_q   <= pos_y;
                flip_q <= flip_h;
            end
            hit_d1_q    <= hit & blank;
            pix_index_q <= rom_q;
            pix_hit_q   <= hit_d1_q && (rom_q != IDX_W'(TRANSP_IDX));
        end
    end

    assign pix_index = pix_index_q;
    assign pix_hit   = pix_hit_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench: unscaled and 2x-scaled renderers sharing stimulus, each
// fed by a synchronous ROM whose texel value is addr[3:0] ^ 5.
module tb_sprite_anim_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, blank, frame_start, flip_h;
    logic       anim_play, anim_loop, anim_restart;
    logic [9:0] DrawX, DrawY, pos_x, pos_y;

    logic [13:0] rom_address, rom_address_s;
    logic [3:0]  rom_q, rom_q_s, pix_index, pix_index_s;
    logic        pix_hit, pix_hit_s, anim_done, anim_done_s;
    logic [1:0]  anim_frame, anim_frame_s;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int x;
        int y;
        bit blk;
        int addr;
        bit hit;
        int idx;
    } px_vec_t;

    function automatic logic [3:0] rom_fn(input logic [13:0] a);
        return a[3:0] ^ 4'h5;
    endfunction

    always @(posedge clk) begin
        rom_q   <= rom_fn(rom_address);
        rom_q_s <= rom_fn(rom_address_s);
    end

    sprite_anim_renderer #(
        .FRAME_HOLD  (2),
        .SCALE_SHIFT (0)
    ) dut (
        .vga_clk (clk), .reset (reset), .DrawX (DrawX), .DrawY (DrawY),
        .blank (blank), .frame_start (frame_start), .pos_x (pos_x), .pos_y (pos_y),
        .flip_h (flip_h), .anim_play (anim_play), .anim_loop (anim_loop),
        .anim_restart (anim_restart), .rom_address (rom_address), .rom_q (rom_q),
        .pix_index (pix_index), .pix_hit (pix_hit), .anim_frame (anim_frame),
        .anim_done (anim_done)
    );

    sprite_anim_renderer #(
        .FRAME_HOLD  (2),
        .SCALE_SHIFT (1)
    ) dut_s (
        .vga_clk (clk), .reset (reset), .DrawX (DrawX), .DrawY (DrawY),
        .blank (blank), .frame_start (frame_start), .pos_x (pos_x), .pos_y (pos_y),
        .flip_h (flip_h), .anim_play (anim_play), .anim_loop (anim_loop),
        .anim_restart (anim_restart), .rom_address (rom_address_s), .rom_q (rom_q_s),
        .pix_index (pix_index_s), .pix_hit (pix_hit_s), .anim_frame (anim_frame_s),
        .anim_done (anim_done_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DrawX        = 10'($urandom_range(0, 1023));
            DrawY        = 10'($urandom_range(0, 1023));
            pos_x        = 10'($urandom_range(0, 1023));
            pos_y        = 10'($urandom_range(0, 1023));
            blank        = 1'($urandom);
            frame_start  = 1'($urandom);
            flip_h       = 1'($urandom);
            anim_play    = 1'($urandom);
            anim_loop    = 1'($urandom);
            anim_restart = 1'($urandom);
            tick();
        end
        $display("reset: hit=%b idx=%0d frame=%0d done=%b", pix_hit, pix_index, anim_frame, anim_done);
        n_vec++; if (pix_hit !== 1'b0) begin n_err++; $display("FAIL reset_pix_hit: got %b want 0", pix_hit); end
        n_vec++; if (pix_index !== 4'd0) begin n_err++; $display("FAIL reset_pix_index: got %0d want 0", pix_index); end
        n_vec++; if (anim_frame !== 2'd0) begin n_err++; $display("FAIL reset_anim_frame: got %0d want 0", anim_frame); end
        n_vec++; if (anim_done !== 1'b0) begin n_err++; $display("FAIL reset_anim_done: got %b want 0", anim_done); end
        blank = 1'b0; frame_start = 1'b0; flip_h = 1'b0; anim_play = 1'b0;
        anim_loop = 1'b0; anim_restart = 1'b0; DrawX = '0; DrawY = '0;
        pos_x = '0; pos_y = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_position();
        px_vec_t v [10] = '{
            '{100,  50, 1'b1,    0, 1'b1,  5},
            '{ 99,  50, 1'b1,    0, 1'b0, -1},
            '{164,  50, 1'b1,    0, 1'b0, -1},
            '{163,  50, 1'b1,   63, 1'b1, 10},
            '{101,  51, 1'b1,   65, 1'b1,  4},
            '{105,  50, 1'b1,    5, 1'b0, -1},
            '{100,  50, 1'b0,    0, 1'b0, -1},
            '{100, 113, 1'b1, 4032, 1'b1,  5},
            '{100, 114, 1'b1,    0, 1'b0, -1},
            '{100,  49, 1'b1,    0, 1'b0, -1}
        };
        pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0;
        pulse_fs();
        for (int i = 0; i < 10; i++) begin
            DrawX = 10'(v[i].x); DrawY = 10'(v[i].y); blank = v[i].blk;
            #1;
            n_vec++; if (rom_address !== 14'(v[i].addr)) begin n_err++;
                $display("FAIL pos_addr[%0d]: got %0d want %0d", i, rom_address, v[i].addr); end
            tick(); tick();
            $display("pos %0d,%0d blank=%0b addr=%0d hit=%0b idx=%0d", v[i].x, v[i].y, v[i].blk, v[i].addr, pix_hit, pix_index);
            n_vec++; if (pix_hit !== v[i].hit) begin n_err++;
                $display("FAIL pos_hit[%0d]: got %b want %b", i, pix_hit, v[i].hit); end
            if (v[i].hit) begin
                n_vec++; if (pix_index !== 4'(v[i].idx)) begin n_err++;
                    $display("FAIL pos_idx[%0d]: got %0d want %0d", i, pix_index, v[i].idx); end
            end
        end
    endtask

    task automatic test_flip();
        px_vec_t v [3] = '{
            '{100, 50, 1'b1,  63, 1'b1, 10},
            '{163, 50, 1'b1,   0, 1'b1,  5},
            '{101, 51, 1'b1, 126, 1'b1, 11}
        };
        flip_h = 1'b1; DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
        #1;
        n_vec++; if (rom_address !== 14'd0) begin n_err++;
            $display("FAIL flip_before_latch: got %0d want 0", rom_address); end
        pulse_fs();
        for (int i = 0; i < 3; i++) begin
            DrawX = 10'(v[i].x); DrawY = 10'(v[i].y); blank = v[i].blk;
            #1;
            n_vec++; if (rom_address !== 14'(v[i].addr)) begin n_err++;
                $display("FAIL flip_addr[%0d]: got %0d want %0d", i, rom_address, v[i].addr); end
            tick(); tick();
            $display("flip %0d,%0d addr=%0d hit=%0b idx=%0d", v[i].x, v[i].y, v[i].addr, pix_hit, pix_index);
            n_vec++; if (pix_hit !== v[i].hit || pix_index !== 4'(v[i].idx)) begin n_err++;
                $display("FAIL flip_pix[%0d]: got hit=%b idx=%0d want hit=%b idx=%0d", i, pix_hit, pix_index, v[i].hit, v[i].idx); end
        end
        flip_h = 1'b0;
        pulse_fs();
    endtask

    task automatic test_scale();
        px_vec_t v [5] = '{
            '{103,  52, 1'b1,   65, 1'b1,  4},
            '{100,  50, 1'b1,    0, 1'b1,  5},
            '{227, 177, 1'b1, 4095, 1'b1, 10},
            '{228,  50, 1'b1,    0, 1'b0, -1},
            '{110,  50, 1'b1,    5, 1'b0, -1}
        };
        for (int i = 0; i < 5; i++) begin
            DrawX = 10'(v[i].x); DrawY = 10'(v[i].y); blank = v[i].blk;
            #1;
            n_vec++; if (rom_address_s !== 14'(v[i].addr)) begin n_err++;
                $display("FAIL scale_addr[%0d]: got %0d want %0d", i, rom_address_s, v[i].addr); end
            tick(); tick();
            $display("scale %0d,%0d addr=%0d hit=%0b idx=%0d", v[i].x, v[i].y, v[i].addr, pix_hit_s, pix_index_s);
            n_vec++; if (pix_hit_s !== v[i].hit) begin n_err++;
                $display("FAIL scale_hit[%0d]: got %b want %b", i, pix_hit_s, v[i].hit); end
            if (v[i].hit) begin
                n_vec++; if (pix_index_s !== 4'(v[i].idx)) begin n_err++;
                    $display("FAIL scale_idx[%0d]: got %0d want %0d", i, pix_index_s, v[i].idx); end
            end
        end
    endtask

    task automatic test_loop_anim();
        int  seq [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
        logic exp_done;
        anim_loop = 1'b1; anim_play = 1'b1; blank = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse_fs();
            exp_done = (i == 7);
            $display("loop pulse %0d frame=%0d done=%b", i + 1, anim_frame, anim_done);
            n_vec++; if (anim_frame !== 2'(seq[i])) begin n_err++;
                $display("FAIL loop_frame[%0d]: got %0d want %0d", i, anim_frame, seq[i]); end
            n_vec++; if (anim_done !== exp_done) begin n_err++;
                $display("FAIL loop_done[%0d]: got %b want %b", i, anim_done, exp_done); end
            tick();
            n_vec++; if (anim_done !== 1'b0) begin n_err++;
                $display("FAIL loop_done_width[%0d]: got %b want 0", i, anim_done); end
        end
        for (int i = 0; i < 4; i++) pulse_fs();
        n_vec++; if (anim_frame !== 2'd2) begin n_err++;
            $display("FAIL loop_frame2: got %0d want 2", anim_frame); end
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
        #1;
        n_vec++; if (rom_address !== 14'd8192) begin n_err++;
            $display("FAIL frame2_addr: got %0d want 8192", rom_address); end
        tick(); tick();
        $display("frame2 origin addr=%0d hit=%b idx=%0d", rom_address, pix_hit, pix_index);
        n_vec++; if (pix_hit !== 1'b1 || pix_index !== 4'd5) begin n_err++;
            $display("FAIL frame2_pix: got hit=%b idx=%0d want hit=1 idx=5", pix_hit, pix_index); end
        blank = 1'b0;
    endtask

    task automatic test_oneshot();
        int  seq [8] = '{0, 1, 1, 2, 2, 3, 3, 3};
        int  tail [4] = '{0, 0, 0, 1};
        logic exp_done;
        anim_loop = 1'b0;
        anim_restart = 1'b1; tick(); anim_restart = 1'b0;
        n_vec++; if (anim_frame !== 2'd0) begin n_err++;
            $display("FAIL oneshot_restart0: got %0d want 0", anim_frame); end
        for (int i = 0; i < 10; i++) begin
            pulse_fs();
            exp_done = (i == 7);
            $display("oneshot pulse %0d frame=%0d done=%b", i + 1, anim_frame, anim_done);
            n_vec++; if (anim_frame !== 2'((i < 8) ? seq[i] : 3)) begin n_err++;
                $display("FAIL oneshot_frame[%0d]: got %0d want %0d", i, anim_frame, (i < 8) ? seq[i] : 3); end
            n_vec++; if (anim_done !== exp_done) begin n_err++;
                $display("FAIL oneshot_done[%0d]: got %b want %b", i, anim_done, exp_done); end
        end
        anim_restart = 1'b1; tick(); anim_restart = 1'b0;
        n_vec++; if (anim_frame !== 2'd0 || anim_done !== 1'b0) begin n_err++;
            $display("FAIL oneshot_restart: got frame=%0d done=%b want 0 0", anim_frame, anim_done); end
        // Step 2 pulses restart together with frame_start: restart must win.
        for (int i = 0; i < 4; i++) begin
            anim_restart = (i == 1);
            pulse_fs();
            anim_restart = 1'b0;
            $display("replay pulse %0d frame=%0d", i + 1, anim_frame);
            n_vec++; if (anim_frame !== 2'(tail[i])) begin n_err++;
                $display("FAIL replay_frame[%0d]: got %0d want %0d", i, anim_frame, tail[i]); end
        end
    endtask

    task automatic test_tearing_reset();
        blank = 1'b1; pos_x = 10'd200;
        DrawX = 10'd100; DrawY = 10'd50;
        #1;
        n_vec++; if (rom_address !== 14'd4096) begin n_err++;
            $display("FAIL tear_midframe: got %0d want 4096", rom_address); end
        pulse_fs();
        n_vec++; if (rom_address !== 14'd0) begin n_err++;
            $display("FAIL tear_old_pos: got %0d want 0", rom_address); end
        DrawX = 10'd200;
        #1;
        n_vec++; if (rom_address !== 14'd4096) begin n_err++;
            $display("FAIL tear_new_pos: got %0d want 4096", rom_address); end
        pulse_fs();
        n_vec++; if (anim_frame !== 2'd2 || rom_address !== 14'd8192) begin n_err++;
            $display("FAIL tear_frame2: got frame=%0d addr=%0d want 2 8192", anim_frame, rom_address); end
        tick(); tick();
        n_vec++; if (pix_hit !== 1'b1) begin n_err++;
            $display("FAIL prereset_hit: got %b want 1", pix_hit); end
        reset = 1'b1; tick();
        $display("midreset hit=%b idx=%0d frame=%0d done=%b", pix_hit, pix_index, anim_frame, anim_done);
        n_vec++; if (pix_hit !== 1'b0 || pix_index !== 4'd0) begin n_err++;
            $display("FAIL midreset_pix: got hit=%b idx=%0d want 0 0", pix_hit, pix_index); end
        n_vec++; if (anim_frame !== 2'd0 || anim_done !== 1'b0) begin n_err++;
            $display("FAIL midreset_anim: got frame=%0d done=%b want 0 0", anim_frame, anim_done); end
        reset = 1'b0;
        DrawX = 10'd10; DrawY = 10'd5;
        #1;
        n_vec++; if (rom_address !== 14'd330) begin n_err++;
            $display("FAIL postreset_shadow: got %0d want 330", rom_address); end
        tick();
        n_vec++; if (pix_hit !== 1'b0) begin n_err++;
            $display("FAIL postreset_flush: got %b want 0", pix_hit); end
        tick();
        n_vec++; if (pix_hit !== 1'b1 || pix_index !== 4'd15) begin n_err++;
            $display("FAIL postreset_pix: got hit=%b idx=%0d want 1 15", pix_hit, pix_index); end
    endtask

    initial begin
        test_reset();
        test_position();
        test_flip();
        test_scale();
        test_loop_anim();
        test_oneshot();
        test_tearing_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
